// File: rtl/nios2_mycpu_div_cell_if.sv
// Request/response bundle between the Nios II A stage and the divider cell.
interface nios2_mycpu_div_cell_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  A_div_start;
    logic                  A_div_abort;
    logic                  A_div_signed;
    logic                  A_div_rem_sel;
    logic [DATA_WIDTH-1:0] A_div_src1;
    logic [DATA_WIDTH-1:0] A_div_src2;
    logic                  A_div_busy;
    logic                  A_div_done;
    logic                  A_div_by_zero;
    logic [DATA_WIDTH-1:0] A_div_cell_result;

    modport master (
        output A_div_start, A_div_abort, A_div_signed, A_div_rem_sel,
               A_div_src1, A_div_src2,
        input  A_div_busy, A_div_done, A_div_by_zero, A_div_cell_result
    );

    modport slave (
        input  A_div_start, A_div_abort, A_div_signed, A_div_rem_sel,
               A_div_src1, A_div_src2,
        output A_div_busy, A_div_done, A_div_by_zero, A_div_cell_result
    );
endinterface

// File: rtl/nios2_mycpu_div_cell.sv
// Iterative radix-2 restoring divider for div/divu and remainder sequences.
// Divides operand magnitudes, then applies sign correction in a final FIX cycle.
module nios2_mycpu_div_cell #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nios2_mycpu_div_cell_if.slave  bus
);
    localparam int unsigned MSB = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t state;
    state_t state_next;

    logic load_c;
    logic step_c;
    logic finish_c;
    logic abort_c;

    logic [CNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] dvd;
    logic [DATA_WIDTH-1:0] dsr;
    logic                  q_neg;
    logic                  r_neg;
    logic                  zero;
    logic                  rem_sel;
    logic                  busy;
    logic                  done;
    logic                  by_zero;
    logic [DATA_WIDTH-1:0] result;

    logic                  src1_neg_c;
    logic                  src2_neg_c;
    logic [DATA_WIDTH-1:0] mag1_c;
    logic [DATA_WIDTH-1:0] mag2_c;
    logic [DATA_WIDTH:0]   rem_shift_c;
    logic [DATA_WIDTH:0]   trial_c;
    logic [DATA_WIDTH-1:0] q_fix_c;
    logic [DATA_WIDTH-1:0] r_fix_c;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes; abort beats start and pre-empts FIX.
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        step_c     = 1'b0;
        finish_c   = 1'b0;
        abort_c    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.A_div_start && !bus.A_div_abort) begin
                    load_c     = 1'b1;
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (bus.A_div_abort) begin
                    abort_c    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    step_c = 1'b1;
                    if (cnt == '0) begin
                        state_next = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (bus.A_div_abort) begin
                    abort_c = 1'b1;
                end else begin
                    finish_c = 1'b1;
                end
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand magnitudes, one restoring trial step, and final sign correction.
    always_comb begin
        src1_neg_c  = bus.A_div_signed && bus.A_div_src1[MSB];
        src2_neg_c  = bus.A_div_signed && bus.A_div_src2[MSB];
        mag1_c      = src1_neg_c ? -bus.A_div_src1 : bus.A_div_src1;
        mag2_c      = src2_neg_c ? -bus.A_div_src2 : bus.A_div_src2;
        rem_shift_c = {rem, dvd[MSB]};
        trial_c     = rem_shift_c - {1'b0, dsr};
        // Zero divisor: quotient all ones; remainder magnitude equals |src1|,
        // so restoring the dividend sign reproduces src1 unmodified.
        q_fix_c     = zero ? '1 : (q_neg ? -dvd : dvd);
        r_fix_c     = r_neg ? -rem : rem;
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            rem     <= '0;
            dvd     <= '0;
            dsr     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            zero    <= 1'b0;
            rem_sel <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            by_zero <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (load_c) begin
                rem_sel <= bus.A_div_rem_sel;
                dvd     <= mag1_c;
                dsr     <= mag2_c;
                q_neg   <= bus.A_div_signed && (bus.A_div_src1[MSB] ^ bus.A_div_src2[MSB]);
                r_neg   <= src1_neg_c;
                zero    <= (bus.A_div_src2 == '0);
                rem     <= '0;
                cnt     <= CNT_WIDTH'(DATA_WIDTH - 1);
                busy    <= 1'b1;
                by_zero <= 1'b0;
            end
            if (step_c) begin
                if (!trial_c[DATA_WIDTH]) begin
                    rem <= trial_c[DATA_WIDTH-1:0];
                    dvd <= {dvd[MSB-1:0], 1'b1};
                end else begin
                    rem <= rem_shift_c[DATA_WIDTH-1:0];
                    dvd <= {dvd[MSB-1:0], 1'b0};
                end
                if (cnt != '0) begin
                    cnt <= cnt - CNT_WIDTH'(1);
                end
            end
            if (finish_c) begin
                result  <= rem_sel ? r_fix_c : q_fix_c;
                by_zero <= zero;
                done    <= 1'b1;
                busy    <= 1'b0;
            end
            if (abort_c) begin
                busy <= 1'b0;
            end
        end
    end

    assign bus.A_div_busy        = busy;
    assign bus.A_div_done        = done;
    assign bus.A_div_by_zero     = by_zero;
    assign bus.A_div_cell_result = result;
endmodule

// File: tb/tb_nios2_mycpu_div_cell.sv
// Directed self-checking bench for the iterative divider cell.
module tb_nios2_mycpu_div_cell;
    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    nios2_mycpu_div_cell_if #(.DATA_WIDTH(32)) bus ();

    nios2_mycpu_div_cell #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (5)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Issue a start from the #1-after-edge phase and wait for done (bounded).
    task automatic run_op(input logic sgn, input logic rs,
                          input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        bus.A_div_signed  = sgn;
        bus.A_div_rem_sel = rs;
        bus.A_div_src1    = a;
        bus.A_div_src2    = b;
        bus.A_div_start   = 1'b1;
        @(posedge clk); #1;
        bus.A_div_start   = 1'b0;
        cycles = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (bus.A_div_done) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.A_div_busy !== 1'b0 || bus.A_div_done !== 1'b0 ||
            bus.A_div_by_zero !== 1'b0 || bus.A_div_cell_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b bz=%b res=%h required 0 0 0 00000000",
                     bus.A_div_busy, bus.A_div_done, bus.A_div_by_zero, bus.A_div_cell_result);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int c;
        run_op(1'b0, 1'b0, 32'd100, 32'd7, c);
        checks++;
        if (c !== 33) begin
            errors++;
            $display("FAIL u100_7_latency: got %0d required 33", c);
        end
        checks++;
        if (bus.A_div_cell_result !== 32'd14) begin
            errors++;
            $display("FAIL u100_7_quot: got %h required 0000000e", bus.A_div_cell_result);
        end
        run_op(1'b0, 1'b1, 32'd100, 32'd7, c);
        checks++;
        if (bus.A_div_cell_result !== 32'd2 || bus.A_div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL u100_7_rem: got %h bz=%b required 00000002 bz=0",
                     bus.A_div_cell_result, bus.A_div_by_zero);
        end
        run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, c);
        checks++;
        if (bus.A_div_cell_result !== 32'h7FFF_FFFC) begin
            errors++;
            $display("FAIL u_fff9_2_quot: got %h required 7ffffffc", bus.A_div_cell_result);
        end
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, c);
        checks++;
        if (bus.A_div_cell_result !== 32'd1) begin
            errors++;
            $display("FAIL u_fff9_2_rem: got %h required 00000001", bus.A_div_cell_result);
        end
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, c);
        checks++;
        if (bus.A_div_cell_result !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL u_max_1_quot: got %h required ffffffff", bus.A_div_cell_result);
        end
    endtask

    task automatic test_signed();
        int c;
        run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, c);
        checks++;
        if (bus.A_div_cell_result !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL s_m7_2_quot: got %h required fffffffd", bus.A_div_cell_result);
        end
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, c);
        checks++;
        if (bus.A_div_cell_result !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL s_m7_2_rem: got %h required ffffffff", bus.A_div_cell_result);
        end
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, c);
        checks++;
        if (bus.A_div_cell_result !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL s_7_m2_quot: got %h required fffffffd", bus.A_div_cell_result);
        end
        run_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, c);
        checks++;
        if (bus.A_div_cell_result !== 32'd1) begin
            errors++;
            $display("FAIL s_7_m2_rem: got %h required 00000001", bus.A_div_cell_result);
        end
    endtask

    task automatic test_overflow();
        int c;
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, c);
        checks++;
        if (bus.A_div_cell_result !== 32'h8000_0000 || bus.A_div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL s_ovf_quot: got %h bz=%b required 80000000 bz=0",
                     bus.A_div_cell_result, bus.A_div_by_zero);
        end
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, c);
        checks++;
        if (bus.A_div_cell_result !== 32'h0) begin
            errors++;
            $display("FAIL s_ovf_rem: got %h required 00000000", bus.A_div_cell_result);
        end
    endtask

    task automatic test_div_zero();
        int c;
        logic [32:0] exp_tab [6];
        logic        sgn_tab [6];
        logic        rs_tab  [6];
        logic [31:0] a_tab   [6];
        // {by_zero, result} for 5/0 and -5/0 in each mode.
        sgn_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        rs_tab  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        a_tab   = '{32'd5, 32'd5, 32'd5, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        exp_tab = '{{1'b1, 32'hFFFF_FFFF}, {1'b1, 32'd5}, {1'b1, 32'hFFFF_FFFF},
                    {1'b1, 32'd5}, {1'b1, 32'hFFFF_FFFF}, {1'b1, 32'hFFFF_FFFB}};
        for (int i = 0; i < 6; i++) begin
            run_op(sgn_tab[i], rs_tab[i], a_tab[i], 32'd0, c);
            checks++;
            if ({bus.A_div_by_zero, bus.A_div_cell_result} !== exp_tab[i] || c !== 33) begin
                errors++;
                $display("FAIL div_zero_%0d: got bz=%b res=%h lat=%0d required bz=%b res=%h lat=33",
                         i, bus.A_div_by_zero, bus.A_div_cell_result, c,
                         exp_tab[i][32], exp_tab[i][31:0]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int dones;
        int done_at;
        int busy_low_at;
        bus.A_div_signed  = 1'b0;
        bus.A_div_rem_sel = 1'b0;
        bus.A_div_src1    = 32'd100;
        bus.A_div_src2    = 32'd7;
        bus.A_div_start   = 1'b1;
        @(posedge clk); #1;
        bus.A_div_start   = 1'b0;
        checks++;
        if (bus.A_div_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b required 1", bus.A_div_busy);
        end
        // Different operands afterwards must not disturb the captured op.
        bus.A_div_signed  = 1'b1;
        bus.A_div_rem_sel = 1'b1;
        bus.A_div_src1    = 32'd1000;
        bus.A_div_src2    = 32'd10;
        dones = 0; done_at = -1; busy_low_at = -1;
        for (int n = 1; n <= 45; n++) begin
            bus.A_div_start = (n == 10);
            @(posedge clk); #1;
            if (bus.A_div_done) begin
                dones++;
                if (done_at < 0) done_at = n;
            end
            if (!bus.A_div_busy && busy_low_at < 0) busy_low_at = n;
        end
        bus.A_div_start = 1'b0;
        checks++;
        if (dones !== 1 || done_at !== 33) begin
            errors++;
            $display("FAIL start_while_busy_done: got %0d pulses at %0d required 1 at 33", dones, done_at);
        end
        checks++;
        if (busy_low_at !== 33) begin
            errors++;
            $display("FAIL busy_fall: got cycle %0d required 33", busy_low_at);
        end
        checks++;
        if (bus.A_div_cell_result !== 32'd14) begin
            errors++;
            $display("FAIL start_while_busy_result: got %h required 0000000e", bus.A_div_cell_result);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        run_op(1'b0, 1'b0, 32'd100, 32'd7, c);
        // Still in the done cycle: start the next op right away.
        run_op(1'b0, 1'b1, 32'd100, 32'd7, c);
        checks++;
        if (c !== 33 || bus.A_div_cell_result !== 32'd2) begin
            errors++;
            $display("FAIL back_to_back: got lat=%0d res=%h required lat=33 res=00000002",
                     c, bus.A_div_cell_result);
        end
    endtask

    task automatic test_abort();
        int c;
        int dones;
        run_op(1'b0, 1'b0, 32'd5, 32'd0, c);
        bus.A_div_signed  = 1'b0;
        bus.A_div_rem_sel = 1'b0;
        bus.A_div_src1    = 32'd100;
        bus.A_div_src2    = 32'd7;
        bus.A_div_start   = 1'b1;
        @(posedge clk); #1;
        bus.A_div_start   = 1'b0;
        dones = 0;
        for (int n = 1; n <= 60; n++) begin
            bus.A_div_abort = (n == 20);
            @(posedge clk); #1;
            if (n == 20) begin
                checks++;
                if (bus.A_div_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_busy: got %b required 0", bus.A_div_busy);
                end
            end
            if (bus.A_div_done) dones++;
        end
        bus.A_div_abort = 1'b0;
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d pulses required 0", dones);
        end
        checks++;
        if (bus.A_div_cell_result !== 32'hFFFF_FFFF || bus.A_div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL abort_result: got %h bz=%b required ffffffff bz=0",
                     bus.A_div_cell_result, bus.A_div_by_zero);
        end
        // Abort together with start in IDLE: nothing starts.
        bus.A_div_start = 1'b1;
        bus.A_div_abort = 1'b1;
        @(posedge clk); #1;
        bus.A_div_start = 1'b0;
        bus.A_div_abort = 1'b0;
        dones = 0;
        checks++;
        if (bus.A_div_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_with_start_busy: got %b required 0", bus.A_div_busy);
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.A_div_done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_with_start_done: got %0d pulses required 0", dones);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        bus.A_div_signed  = 1'b0;
        bus.A_div_rem_sel = 1'b0;
        bus.A_div_src1    = 32'd1000;
        bus.A_div_src2    = 32'd3;
        bus.A_div_start   = 1'b1;
        @(posedge clk); #1;
        bus.A_div_start   = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.A_div_busy !== 1'b0 || bus.A_div_done !== 1'b0 ||
            bus.A_div_by_zero !== 1'b0 || bus.A_div_cell_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b bz=%b res=%h required 0 0 0 00000000",
                     bus.A_div_busy, bus.A_div_done, bus.A_div_by_zero, bus.A_div_cell_result);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 1'b0, 32'd100, 32'd7, c);
        checks++;
        if (c !== 33 || bus.A_div_cell_result !== 32'd14) begin
            errors++;
            $display("FAIL after_reset_op: got lat=%0d res=%h required lat=33 res=0000000e",
                     c, bus.A_div_cell_result);
        end
    endtask

    initial begin
        clk               = 1'b0;
        reset_n           = 1'b0;
        errors            = 0;
        checks            = 0;
        bus.A_div_start   = 1'b0;
        bus.A_div_abort   = 1'b0;
        bus.A_div_signed  = 1'b0;
        bus.A_div_rem_sel = 1'b0;
        bus.A_div_src1    = 32'h0;
        bus.A_div_src2    = 32'h0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_start_while_busy();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
